// File: rtl/gb_cpu_fetch_unit.sv
// Opcode fetch/dispatch front end: fetches opcode bytes (with CB prefix), holds them for the
// sequencer, and handles HALT and interrupt dispatch. Optional macro: GB_CPU_HALT_BUG_EN.
module gb_cpu_fetch_unit (
    input  logic       clk,
    input  logic       reset,
    output logic       fetch_req,
    input  logic       fetch_valid,
    input  logic [7:0] fetch_data,
    output logic       pc_inc,
    output logic [7:0] opcode,
    output logic       cb_prefix,
    output logic       isr_cmd,
    output logic       dec_valid,
    input  logic       instr_done,
    input  logic       halt_exec,
    input  logic       ime,
    input  logic       int_pending,
    output logic       halted
);

    localparam int unsigned OPCODE_W = 8;
    localparam logic [OPCODE_W-1:0] CB_BYTE  = OPCODE_W'(8'hCB);
    localparam logic [OPCODE_W-1:0] NOP_BYTE = OPCODE_W'(8'h00);

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_FETCH_CB = 2'd1,
        ST_EXEC     = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    state_e              state_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic                cb_q;
    logic                isr_q;
    logic                bug_suppress;

`ifdef GB_CPU_HALT_BUG_EN
    // Set when HALT exits straight to fetch with IME clear; eats the next PC increment.
    logic halt_bug_q;
    assign bug_suppress = halt_bug_q && (state_q == ST_FETCH);
`else
    assign bug_suppress = 1'b0;
`endif

    assign fetch_req = (state_q == ST_FETCH) || (state_q == ST_FETCH_CB);
    assign dec_valid = (state_q == ST_EXEC);
    assign halted    = (state_q == ST_HALT);
    assign opcode    = opcode_q;
    assign cb_prefix = cb_q;
    assign isr_cmd   = isr_q;

    // PC advances in the same cycle a fetched byte is accepted.
    assign pc_inc = !reset && fetch_req && fetch_valid && !bug_suppress;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            opcode_q   <= NOP_BYTE;
            cb_q       <= 1'b0;
            isr_q      <= 1'b0;
`ifdef GB_CPU_HALT_BUG_EN
            halt_bug_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (fetch_valid) begin
`ifdef GB_CPU_HALT_BUG_EN
                        halt_bug_q <= 1'b0;
`endif
                        if (fetch_data == CB_BYTE) begin
                            state_q <= ST_FETCH_CB;
                        end else begin
                            opcode_q <= fetch_data;
                            cb_q     <= 1'b0;
                            isr_q    <= 1'b0;
                            state_q  <= ST_EXEC;
                        end
                    end
                end
                ST_FETCH_CB: begin
                    if (fetch_valid) begin
                        opcode_q <= fetch_data;
                        cb_q     <= 1'b1;
                        isr_q    <= 1'b0;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Instruction boundary: the only point where interrupts are considered.
                    if (instr_done) begin
                        if (halt_exec && !int_pending) begin
                            state_q <= ST_HALT;
                        end else if (ime && int_pending) begin
                            opcode_q <= NOP_BYTE;
                            cb_q     <= 1'b0;
                            isr_q    <= 1'b1;
                            state_q  <= ST_EXEC;
                        end else begin
                            state_q <= ST_FETCH;
`ifdef GB_CPU_HALT_BUG_EN
                            if (halt_exec) begin
                                halt_bug_q <= 1'b1;
                            end
`endif
                        end
                    end
                end
                ST_HALT: begin
                    if (int_pending) begin
                        if (ime) begin
                            opcode_q <= NOP_BYTE;
                            cb_q     <= 1'b0;
                            isr_q    <= 1'b1;
                            state_q  <= ST_EXEC;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_cpu_fetch_unit.sv
// Directed and random stimulus for gb_cpu_fetch_unit, checked against a transaction-level
// model of the fetch/execute/halt behaviour.
module tb_gb_cpu_fetch_unit;

    logic       clk;
    logic       reset;
    logic       fetch_req;
    logic       fetch_valid;
    logic [7:0] fetch_data;
    logic       pc_inc;
    logic [7:0] opcode;
    logic       cb_prefix;
    logic       isr_cmd;
    logic       dec_valid;
    logic       instr_done;
    logic       halt_exec;
    logic       ime;
    logic       int_pending;
    logic       halted;

    gb_cpu_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .pc_inc     (pc_inc),
        .opcode     (opcode),
        .cb_prefix  (cb_prefix),
        .isr_cmd    (isr_cmd),
        .dec_valid  (dec_valid),
        .instr_done (instr_done),
        .halt_exec  (halt_exec),
        .ime        (ime),
        .int_pending(int_pending),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the CPU front end is doing right now.
    logic       m_exec    = 1'b0;  // an instruction (or ISR) is executing
    logic       m_halted  = 1'b0;  // CPU sleeping after HALT
    logic       m_prefix  = 1'b0;  // CB seen, waiting for the second byte
    logic       m_bug     = 1'b0;  // next PC increment is swallowed
    logic [7:0] m_op      = 8'h00;
    logic       m_cb      = 1'b0;
    logic       m_isr     = 1'b0;

    // Snapshot of DUT outputs taken in the most recent cycle.
    logic       o_fr, o_pc, o_dv, o_halt, o_cb, o_isr;
    logic [7:0] o_op;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic isr_issue();
        m_exec  = 1'b1;
        m_op    = 8'h00;
        m_cb    = 1'b0;
        m_isr   = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare every output to the model, then advance the model.
    task automatic tick(input logic t_rst, input logic t_fv, input logic [7:0] t_fd,
                        input logic t_done, input logic t_hx, input logic t_ime, input logic t_ip);
        logic e_fr, e_pc;
        @(negedge clk);
        reset       = t_rst;
        fetch_valid = t_fv;
        fetch_data  = t_fd;
        instr_done  = t_done;
        halt_exec   = t_hx;
        ime         = t_ime;
        int_pending = t_ip;
        #1;
        o_fr = fetch_req; o_pc = pc_inc; o_dv = dec_valid; o_halt = halted;
        o_op = opcode; o_cb = cb_prefix; o_isr = isr_cmd;

        e_fr = !m_exec && !m_halted;
        e_pc = !t_rst && e_fr && t_fv && !(m_bug && !m_prefix);
        chk1("fetch_req", o_fr, e_fr);
        chk1("pc_inc", o_pc, e_pc);
        chk1("dec_valid", o_dv, m_exec);
        chk1("halted", o_halt, m_halted);
        chk8("opcode", o_op, m_op);
        chk1("cb_prefix", o_cb, m_cb);
        chk1("isr_cmd", o_isr, m_isr);

        if (t_rst) begin
            m_exec = 1'b0; m_halted = 1'b0; m_prefix = 1'b0; m_bug = 1'b0;
            m_op = 8'h00; m_cb = 1'b0; m_isr = 1'b0;
        end else if (m_halted) begin
            if (t_ip) begin
                m_halted = 1'b0;
                if (t_ime) isr_issue();
            end
        end else if (m_exec) begin
            if (t_done) begin
                if (t_hx && !t_ip) begin
                    m_exec = 1'b0;
                    m_halted = 1'b1;
                end else if (t_ime && t_ip) begin
                    isr_issue();
                end else begin
                    m_exec = 1'b0;
`ifdef GB_CPU_HALT_BUG_EN
                    if (t_hx) m_bug = 1'b1;
`endif
                end
            end
        end else if (t_fv) begin
            if (m_prefix) begin
                m_prefix = 1'b0;
                m_exec = 1'b1; m_op = t_fd; m_cb = 1'b1; m_isr = 1'b0;
            end else begin
                m_bug = 1'b0;
                if (t_fd == 8'hCB) begin
                    m_prefix = 1'b1;
                end else begin
                    m_exec = 1'b1; m_op = t_fd; m_cb = 1'b0; m_isr = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic exp_bug_pc;
        reset = 1'b1; fetch_valid = 1'b0; fetch_data = 8'h00; instr_done = 1'b0;
        halt_exec = 1'b0; ime = 1'b0; int_pending = 1'b0;

        // Reset state, with inputs active to show reset dominates.
        tick(1, 1, 8'h3C, 1, 1, 1, 1);
        tick(1, 1, 8'hCB, 1, 1, 1, 1);
        chk1("rst_dec_valid", o_dv, 1'b0);
        chk8("rst_opcode", o_op, 8'h00);
        chk1("rst_pc_inc", o_pc, 1'b0);
        chk1("rst_halted", o_halt, 1'b0);
        tick(0, 0, 8'h00, 0, 0, 0, 0);
        chk1("post_rst_fetch_req", o_fr, 1'b1);

        // Plain opcode fetch and one-cycle latency to decode.
        tick(0, 1, 8'h3C, 0, 0, 0, 0);
        chk1("fetch3c_pc_inc", o_pc, 1'b1);
        tick(0, 1, 8'h11, 0, 0, 0, 0);
        chk1("exec3c_dec_valid", o_dv, 1'b1);
        chk8("exec3c_opcode", o_op, 8'h3C);
        chk1("exec3c_cb", o_cb, 1'b0);
        chk1("exec3c_no_pc_inc", o_pc, 1'b0);
        tick(0, 0, 8'h00, 1, 0, 0, 0);

        // CB page, second byte also CB.
        tick(0, 1, 8'hCB, 0, 0, 1, 1);
        chk1("cb1_pc_inc", o_pc, 1'b1);
        tick(0, 1, 8'hCB, 1, 0, 1, 1);
        chk1("cb2_pc_inc", o_pc, 1'b1);
        chk1("cb2_fetch_req", o_fr, 1'b1);
        tick(0, 0, 8'h00, 0, 0, 0, 0);
        chk8("cbcb_opcode", o_op, 8'hCB);
        chk1("cbcb_cb", o_cb, 1'b1);
        chk1("cbcb_dec_valid", o_dv, 1'b1);

        // Interrupt taken at the instruction boundary.
        tick(0, 0, 8'h00, 1, 0, 1, 1);
        tick(0, 1, 8'h55, 0, 0, 0, 0);
        chk1("isr_cmd", o_isr, 1'b1);
        chk8("isr_opcode", o_op, 8'h00);
        chk1("isr_fetch_req", o_fr, 1'b0);
        chk1("isr_pc_inc", o_pc, 1'b0);
        tick(0, 0, 8'h00, 1, 0, 0, 0);

        // HALT, then wake with IME clear.
        tick(0, 1, 8'h76, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 1, 1, 0, 0);
        tick(0, 1, 8'h12, 1, 1, 1, 0);
        chk1("halt_halted", o_halt, 1'b1);
        chk1("halt_fetch_req", o_fr, 1'b0);
        tick(0, 0, 8'h00, 0, 0, 0, 1);
        tick(0, 0, 8'h00, 0, 0, 0, 0);
        chk1("wake_halted", o_halt, 1'b0);
        chk1("wake_fetch_req", o_fr, 1'b1);

        // HALT with an interrupt already pending and IME clear.
        tick(0, 1, 8'h76, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 1, 1, 0, 1);
        tick(0, 1, 8'h04, 0, 0, 0, 0);
`ifdef GB_CPU_HALT_BUG_EN
        exp_bug_pc = 1'b0;
`else
        exp_bug_pc = 1'b1;
`endif
        chk1("haltbug_pc_inc", o_pc, exp_bug_pc);
        tick(0, 0, 8'h00, 1, 0, 0, 0);
        chk8("haltbug_opcode", o_op, 8'h04);
        tick(0, 1, 8'h00, 0, 0, 0, 0);
        chk1("after_haltbug_pc_inc", o_pc, 1'b1);
        tick(0, 0, 8'h00, 1, 0, 0, 0);

        // HALT woken with IME set dispatches the interrupt.
        tick(0, 1, 8'h76, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 1, 1, 1, 0);
        tick(0, 0, 8'h00, 0, 0, 1, 1);
        tick(0, 0, 8'h00, 0, 0, 0, 0);
        chk1("halt_isr_cmd", o_isr, 1'b1);
        chk1("halt_isr_halted", o_halt, 1'b0);
        tick(0, 0, 8'h00, 1, 0, 0, 0);

        // Reset aborts FETCH_CB; following byte is not treated as CB page.
        tick(0, 1, 8'hCB, 0, 0, 0, 0);
        tick(1, 1, 8'h05, 0, 0, 0, 0);
        chk1("rst_in_cb_pc_inc", o_pc, 1'b0);
        tick(0, 0, 8'h00, 0, 0, 0, 0);
        chk1("rst_cb_fetch_req", o_fr, 1'b1);
        chk1("rst_cb_cb", o_cb, 1'b0);
        chk1("rst_cb_dec_valid", o_dv, 1'b0);
        tick(0, 1, 8'h05, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 1, 0, 0, 0);
        chk8("rst_cb_opcode", o_op, 8'h05);
        chk1("rst_cb_cb2", o_cb, 1'b0);

        // Reset aborts HALT.
        tick(0, 1, 8'h76, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 1, 1, 0, 0);
        tick(1, 0, 8'h00, 0, 0, 0, 0);
        tick(0, 0, 8'h00, 0, 0, 0, 0);
        chk1("rst_halt_halted", o_halt, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(3) == 0) ? 8'hCB : 8'($urandom);
            tick(($urandom_range(63) == 0), $urandom_range(1) == 1, d,
                 $urandom_range(2) == 0, $urandom_range(3) == 0,
                 $urandom_range(1) == 1, $urandom_range(2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_cpu_fetch_unit.md
GB_CPU_FETCH_UNIT -- requirements
Module: gb_cpu_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port fetch_req, output, 1 bit: requests the opcode byte at PC.
REQ-004 SHALL have port fetch_valid, input, 1 bit: fetch_data is valid this cycle.
REQ-005 SHALL have port fetch_data, input, 8 bits: fetched byte.
REQ-006 SHALL have port pc_inc, output, 1 bit: one-cycle pulse, PC += 1.
REQ-007 SHALL have port opcode, output, 8 bits: opcode presented to the decoder.
REQ-008 SHALL have port cb_prefix, output, 1 bit: opcode belongs to the CB page.
REQ-009 SHALL have port isr_cmd, output, 1 bit: the decoder shall emit the interrupt-dispatch schedule.
REQ-010 SHALL have port dec_valid, output, 1 bit: opcode, cb_prefix and isr_cmd are stable and executing.
REQ-011 SHALL have port instr_done, input, 1 bit: sequencer is in the last M-cycle of the current schedule.
REQ-012 SHALL have port halt_exec, input, 1 bit: qualifies instr_done; the finishing instruction is HALT.
REQ-013 SHALL have port ime, input, 1 bit: interrupt master enable.
REQ-014 SHALL have port int_pending, input, 1 bit: (IE & IF) != 0.
REQ-015 SHALL have port halted, output, 1 bit: CPU is in the HALT state.

Function
REQ-016 SHALL implement a registered FSM with states FETCH, FETCH_CB, EXEC and HALT.
REQ-017 In FETCH and in FETCH_CB, fetch_req SHALL be 1; in EXEC and in HALT, fetch_req SHALL be 0.
REQ-018 In FETCH, when fetch_valid=1 and fetch_data=0xCB: pc_inc=1 in the same cycle, next state FETCH_CB.
REQ-019 In FETCH, when fetch_valid=1 and fetch_data!=0xCB: pc_inc=1 in the same cycle; next cycle opcode=fetch_data, cb_prefix=0, isr_cmd=0, state EXEC.
REQ-020 In FETCH_CB, when fetch_valid=1 (any value, including 0xCB): pc_inc=1; next cycle opcode=fetch_data, cb_prefix=1, isr_cmd=0, state EXEC.
REQ-021 In FETCH or FETCH_CB with fetch_valid=0: hold state, no pc_inc.
REQ-022 fetch_valid SHALL be ignored in EXEC and in HALT.
REQ-023 dec_valid SHALL be 1 exactly in EXEC; opcode, cb_prefix and isr_cmd SHALL not change while dec_valid=1.
REQ-024 Latency: fetch_valid accepted in cycle N -> dec_valid=1 in cycle N+1.
REQ-025 In EXEC with instr_done=1 and halt_exec=0: if ime & int_pending, next cycle EXEC with isr_cmd=1, cb_prefix=0, opcode=0x00, and no fetch; else next cycle FETCH.
REQ-026 In EXEC with instr_done=1 and halt_exec=1:
  - int_pending=0 -> HALT.
  - int_pending=1 and ime=1 -> EXEC with isr_cmd=1.
  - int_pending=1 and ime=0 -> FETCH; HALT is not entered (see REQ-033).
REQ-027 HALT: halted=1; hold while int_pending=0; when int_pending=1: if ime, next cycle EXEC with isr_cmd=1; else next cycle FETCH.
REQ-028 instr_done and halt_exec SHALL be ignored outside EXEC.
REQ-029 ime and int_pending SHALL be sampled only at the boundaries in REQ-025 to REQ-027; an interrupt SHALL never split CB from its opcode byte.
REQ-030 pc_inc SHALL never be asserted for an isr_cmd issue.

Reset
REQ-031 While reset=1: state FETCH, opcode=0x00, cb_prefix=0, isr_cmd=0, dec_valid=0, pc_inc=0, halted=0, halt-bug flag cleared; fetch_req=1 from the first cycle after reset deasserts.
REQ-032 Reset SHALL dominate all inputs and abort any state, including FETCH_CB and HALT.

Configuration
REQ-033 Macro GB_CPU_HALT_BUG_EN: when defined, the REQ-026 ime=0 path sets a flag that suppresses pc_inc on the next accepted fetch only, then clears; when undefined, no flag exists and the fetch increments normally.

Verification
REQ-034 Reset, then fetch_valid with data 0x3C -> pc_inc=1 same cycle; next cycle dec_valid=1, opcode=0x3C, cb_prefix=0.
REQ-035 Fetch 0xCB, then 0xCB -> two pc_inc pulses; opcode=0xCB, cb_prefix=1, dec_valid=1.
REQ-036 In EXEC, instr_done=1 with ime=1 and int_pending=1 -> next cycle isr_cmd=1, opcode=0x00, fetch_req=0, no pc_inc.
REQ-037 HALT executed (instr_done=1, halt_exec=1) with int_pending=0 -> halted=1; raise int_pending with ime=0 -> FETCH, halted=0.
REQ-038 HALT with ime=0 and int_pending=1, then fetch 0x04 -> pc_inc=0 with GB_CPU_HALT_BUG_EN defined, pc_inc=1 without; opcode=0x04 in both builds.
REQ-039 Assert reset in FETCH_CB -> next cycle state FETCH, cb_prefix=0, dec_valid=0.
